// File: rtl/bus_arbiter.sv
// Shares the bexkat1 memory bus between the instruction-fetch and data ports.
// Ownership changes only at transaction boundaries; data wins unless fetch has starved.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_cyc,
  input  logic [31:0] if_adr,
  output logic        if_ack,
  output logic        if_err,
  output logic        if_stall,
  output logic [31:0] if_dat_i,
  input  logic        d_cyc,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_dat_o,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_dat_i,
  output logic        bus_cyc,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat_o,
  input  logic        bus_ack,
  input  logic [31:0] bus_dat_i
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_IF, S_DAT} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [7:0] wdog_q, wdog_d;
  logic       data_wins;
  logic       owned;
  logic       wdog_hit;
  logic       ack_ok;

  always_comb begin
    data_wins = d_cyc && (!if_cyc || (starve_q < STARVE_MAX));
    state_d   = state_q;
    case (state_q)
      S_IDLE: begin
        if (data_wins)   state_d = S_DAT;
        else if (if_cyc) state_d = S_IF;
      end
      S_IF: begin
        if (!if_cyc) state_d = d_cyc ? S_DAT : S_IDLE;
      end
      S_DAT: begin
        // Data drop re-arbitrates exactly like idle so a waiting fetch is handed over directly.
        if (!d_cyc) begin
          if (data_wins)   state_d = S_DAT;
          else if (if_cyc) state_d = S_IF;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    starve_d = starve_q;
    if (state_d == S_IF && state_q != S_IF)
      starve_d = '0;
    else if (state_d == S_DAT && state_q != S_DAT && if_cyc && starve_q < STARVE_MAX)
      starve_d = starve_q + 4'd1;

    owned    = (state_q != S_IDLE);
    wdog_hit = owned && !bus_ack && (wdog_q == WDOG_LAST);
    wdog_d   = wdog_q + 8'd1;
    if (!owned || bus_ack || state_d != state_q || wdog_hit)
      wdog_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wdog_q   <= wdog_d;
    end
  end

  // An asserted reset abandons the cycle in flight, so nothing is reported to either port.
  assign ack_ok = bus_ack && !rst_i;

  assign if_ack   = (state_q == S_IF)  && ack_ok;
  assign d_ack    = (state_q == S_DAT) && ack_ok;
  assign if_err   = (state_q == S_IF)  && wdog_hit && !rst_i;
  assign d_err    = (state_q == S_DAT) && wdog_hit && !rst_i;
  assign if_stall = if_cyc && (state_q != S_IF);
  assign if_dat_i = bus_dat_i;
  assign d_dat_i  = bus_dat_i;

  assign bus_cyc   = owned;
  assign bus_we    = (state_q == S_DAT) ? d_we : 1'b0;
  assign bus_sel   = (state_q == S_DAT) ? d_sel : ((state_q == S_IF) ? 4'hf : 4'h0);
  assign bus_adr   = (state_q == S_DAT) ? d_adr : ((state_q == S_IF) ? if_adr : 32'h0);
  assign bus_dat_o = (state_q == S_DAT) ? d_dat_o : 32'h0;

endmodule
